// File: rtl/sg_list_pkg.sv
// sg_list_pkg
//   Shared definitions for the scatter-gather list writer/reader pair:
//   SG entry field offsets, element geometry, holding-buffer sizing,
//   writer FSM state encoding and a DATA_EN saturation helper.
package sg_list_pkg;

    // SG buffer FIFO entry layout
    localparam int unsigned SG_ADDR_LSB    = 0;
    localparam int unsigned SG_LEN_LSB     = 64;
    localparam int unsigned SG_ENTRY_USED  = 96;

    // One SG element = address low, address high, length
    localparam int unsigned SG_ELEM_DWORDS = 3;

    // Holding buffer depth and maximum dwords per input beat
    localparam int unsigned SG_HOLD_DWORDS = 10;
    localparam int unsigned SG_BEAT_DWORDS = 8;

    typedef enum logic {
        S_SGW256_RUN   = 1'b0,
        S_SGW256_FLUSH = 1'b1
    } sgw256_state_e;

    // DATA_EN values above one full beat are treated as a full beat
    function automatic logic [3:0] sg_sat_dword_cnt(input logic [3:0] en);
        return (en > 4'(SG_BEAT_DWORDS)) ? 4'(SG_BEAT_DWORDS) : en;
    endfunction

endpackage

// File: rtl/sg_dword_packer.sv
// sg_dword_packer
//   10-dword holding buffer. Each cycle it can drop the oldest element
//   (shift down by 3 dwords) and then append N new dwords directly after
//   whatever remains, preserving dword order.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   clr            discard all held dwords (count -> 0)
//   shift          remove the lowest 3 dwords (caller guarantees cnt >= 3)
//   append         append append_cnt dwords from append_data[dword 0..]
//   append_cnt     0..8, caller guarantees the result fits in 10 dwords
//   append_data    256-bit beat, dword 0 in [31:0]
//   cnt            number of held dwords (0..10)
//   head           lowest 3 held dwords, dword 0 in [31:0]
import sg_list_pkg::*;

module sg_dword_packer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         shift,
    input  logic         append,
    input  logic [3:0]   append_cnt,
    input  logic [255:0] append_data,
    output logic [3:0]   cnt,
    output logic [95:0]  head
);

    logic [SG_HOLD_DWORDS-1:0][31:0] hold_q, hold_d;
    logic [SG_HOLD_DWORDS-1:0][31:0] shifted;
    logic [SG_BEAT_DWORDS-1:0][31:0] in_dw;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] base;
    logic [3:0] slot;
    logic [3:0] off;

    assign in_dw = append_data;

    always_comb begin
        shifted = hold_q;
        base    = cnt_q;
        slot    = '0;
        off     = '0;
        if (shift) begin
            shifted = hold_q >> (SG_ELEM_DWORDS * 32);
            base    = cnt_q - 4'(SG_ELEM_DWORDS);
        end

        // New dwords land at slots [base, base+append_cnt)
        hold_d = shifted;
        for (int unsigned i = 0; i < SG_HOLD_DWORDS; i++) begin
            slot = 4'(i);
            off  = slot - base;
            if (append && (slot >= base) && (slot < base + append_cnt)) begin
                hold_d[i] = in_dw[off[2:0]];
            end
        end

        if (clr) begin
            cnt_d = '0;
        end else if (append) begin
            cnt_d = base + append_cnt;
        end else begin
            cnt_d = base;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign head = {hold_q[2], hold_q[1], hold_q[0]};

endmodule

// File: rtl/sg_list_writer_256.sv
// sg_list_writer_256
//   Packs SG element dwords from the RX completion stream into one 256-bit
//   SG buffer FIFO entry per element: [63:0]=address, [95:64]=length,
//   [255:96]=0. Absorbs 0..8 dwords per beat, emits at most one element
//   per cycle, and stalls the source when a full beat might not fit.
// Ports:
//   CLK, RST_N              clock, synchronous active-low reset
//   DATA, DATA_EN           beat payload and valid dword count (9..15 -> 8)
//   DATA_VALID, DATA_READY  beat handshake
//   FLUSH, FLUSH_DONE       end-of-list request / one-cycle completion pulse
//   ERR                     sticky: a flush discarded a partial element
//   BUF_DATA, BUF_DATA_WEN  SG buffer FIFO write port
//   BUF_DATA_FULL           SG buffer FIFO full
// Build option:
//   SG_LIST_WRITER_ZERO_LEN_SKIP_EN - zero-length elements are dropped
//   without a FIFO write, even while the FIFO is full.
import sg_list_pkg::*;

module sg_list_writer_256 #(
    parameter int C_DATA_WIDTH = 256
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [C_DATA_WIDTH-1:0] DATA,
    input  logic [3:0]              DATA_EN,
    input  logic                    DATA_VALID,
    output logic                    DATA_READY,
    input  logic                    FLUSH,
    output logic                    FLUSH_DONE,
    output logic                    ERR,
    output logic [C_DATA_WIDTH-1:0] BUF_DATA,
    output logic                    BUF_DATA_WEN,
    input  logic                    BUF_DATA_FULL
);

    localparam logic [3:0] ELEM_CNT  = 4'(SG_ELEM_DWORDS);
    localparam logic [3:0] READY_MAX = 4'(SG_HOLD_DWORDS - SG_BEAT_DWORDS);

    sgw256_state_e state_q, state_d;
    logic          flush_done_q, flush_done_d;
    logic          err_q, err_d;

    logic [3:0]    cnt;
    logic [95:0]   head;
    logic          has_elem;
    logic          skip;
    logic          emit;
    logic          consume;
    logic [3:0]    cnt_after;
    logic          accept;
    logic          clr;

    sg_dword_packer u_packer (
        .clk         (CLK),
        .rst_n       (RST_N),
        .clr         (clr),
        .shift       (consume),
        .append      (accept),
        .append_cnt  (sg_sat_dword_cnt(DATA_EN)),
        .append_data (DATA),
        .cnt         (cnt),
        .head        (head)
    );

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        err_d        = err_q;
        clr          = 1'b0;

        has_elem = (cnt >= ELEM_CNT);
`ifdef SG_LIST_WRITER_ZERO_LEN_SKIP_EN
        skip = RST_N & has_elem & (head[SG_LEN_LSB +: 32] == 32'd0);
        emit = RST_N & has_elem & (head[SG_LEN_LSB +: 32] != 32'd0) & !BUF_DATA_FULL;
`else
        skip = 1'b0;
        emit = RST_N & has_elem & !BUF_DATA_FULL;
`endif
        consume   = emit | skip;
        cnt_after = consume ? (cnt - ELEM_CNT) : cnt;

        // Ready only when a worst-case 8-dword beat fits after this cycle's drain.
        // RST_N gating keeps the handshake and FIFO port quiet while in reset.
        DATA_READY = RST_N & (state_q == S_SGW256_RUN) & (cnt_after <= READY_MAX);
        accept     = DATA_VALID & DATA_READY;

        case (state_q)
            S_SGW256_RUN: begin
                if (FLUSH) begin
                    state_d = S_SGW256_FLUSH;
                end
            end
            S_SGW256_FLUSH: begin
                // Complete elements drain first; leftover dwords are an error
                if (cnt < ELEM_CNT) begin
                    if (cnt != 4'd0) begin
                        err_d = 1'b1;
                    end
                    clr          = 1'b1;
                    flush_done_d = 1'b1;
                    state_d      = S_SGW256_RUN;
                end
            end
            default: state_d = S_SGW256_RUN;
        endcase

        BUF_DATA                               = '0;
        BUF_DATA[SG_ENTRY_USED-1:SG_ADDR_LSB] = head;
        BUF_DATA_WEN                           = emit;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= S_SGW256_RUN;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
        end
    end

    assign FLUSH_DONE = flush_done_q;
    assign ERR        = err_q;

endmodule
